// File: rtl/slot_payout_scorer.sv
// Scores a four-reel spin: gates spin requests on the credit balance, latches the
// stopped reels, classifies the pattern and pays into a saturating credit counter.
module slot_payout_scorer #(
    parameter int CREDIT_W    = 8,
    parameter int INIT_CREDIT = 20,
    parameter int BET         = 1,
    parameter int PAY_JACKPOT = 50,
    parameter int PAY_THREE   = 10,
    parameter int PAY_TWOPAIR = 5,
    parameter int PAY_PAIR    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stopInt,
    input  logic                allStopped,
    input  logic [3:0]          randNum1,
    input  logic [3:0]          randNum2,
    input  logic [3:0]          randNum3,
    input  logic [3:0]          randNum4,
    output logic [CREDIT_W-1:0] credits,
    output logic [CREDIT_W-1:0] lastWin,
    output logic [2:0]          winClass,
    output logic                resultValid,
    output logic                busy,
    output logic                noCredit
);

    typedef enum logic [1:0] {IDLE, SPIN, SCORE, HOLD} state_t;

    localparam logic [CREDIT_W-1:0] BET_C = CREDIT_W'(BET);

    state_t              r_state;
    logic                r_stopIntQ;
    logic [3:0]          r_reel1, r_reel2, r_reel3, r_reel4;
    logic [CREDIT_W-1:0] r_credits;
    logic [CREDIT_W-1:0] r_lastWin;
    logic [2:0]          r_winClass;
    logic                r_resultValid;

    logic                w_rise;
    logic [2:0]          w_pairCount;
    logic [CREDIT_W-1:0] w_payout;
    logic [2:0]          w_class;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W-1:0] w_satSum;

    assign w_rise = stopInt & ~r_stopIntQ;

    // Equal pairings among the six reel combinations: 6, 3, 2, 1 or 0 map to the win classes.
    assign w_pairCount = 3'(r_reel1 == r_reel2) + 3'(r_reel1 == r_reel3) + 3'(r_reel1 == r_reel4)
                       + 3'(r_reel2 == r_reel3) + 3'(r_reel2 == r_reel4) + 3'(r_reel3 == r_reel4);

    always_comb begin
        w_payout = '0;
        w_class  = 3'd0;
        case (w_pairCount)
            3'd6: begin w_payout = CREDIT_W'(PAY_JACKPOT); w_class = 3'd4; end
            3'd3: begin w_payout = CREDIT_W'(PAY_THREE);   w_class = 3'd3; end
            3'd2: begin w_payout = CREDIT_W'(PAY_TWOPAIR); w_class = 3'd2; end
            3'd1: begin w_payout = CREDIT_W'(PAY_PAIR);    w_class = 3'd1; end
            default: begin w_payout = '0; w_class = 3'd0; end
        endcase
    end

    assign w_sum    = {1'b0, r_credits} + {1'b0, w_payout};
    assign w_satSum = w_sum[CREDIT_W] ? '1 : w_sum[CREDIT_W-1:0];

    // The request history is kept through reset so a request still held afterwards does not start a spin.
    always_ff @(posedge clk) begin
        r_stopIntQ <= stopInt;
        if (reset) begin
            r_state       <= IDLE;
            r_credits     <= CREDIT_W'(INIT_CREDIT);
            r_lastWin     <= '0;
            r_winClass    <= 3'd0;
            r_resultValid <= 1'b0;
            r_reel1       <= 4'd0;
            r_reel2       <= 4'd0;
            r_reel3       <= 4'd0;
            r_reel4       <= 4'd0;
        end else begin
            r_resultValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise && (r_credits >= BET_C)) begin
                        r_credits <= r_credits - BET_C;
                        r_state   <= SPIN;
                    end
                end
                SPIN: begin
                    // A dropped request refunds the bet even if the reels stopped in the same cycle.
                    if (!stopInt) begin
                        r_credits <= r_credits + BET_C;
                        r_state   <= IDLE;
                    end else if (allStopped) begin
                        r_reel1 <= randNum1;
                        r_reel2 <= randNum2;
                        r_reel3 <= randNum3;
                        r_reel4 <= randNum4;
                        r_state <= SCORE;
                    end
                end
                SCORE: begin
                    r_lastWin     <= w_payout;
                    r_winClass    <= w_class;
                    r_credits     <= w_satSum;
                    r_resultValid <= 1'b1;
                    r_state       <= HOLD;
                end
                HOLD: begin
                    if (!stopInt) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign credits     = r_credits;
    assign lastWin     = r_lastWin;
    assign winClass    = r_winClass;
    assign resultValid = r_resultValid;
    assign busy        = (r_state != IDLE);
    assign noCredit    = (r_credits < BET_C);

endmodule

// File: tb/tb_slot_payout_scorer.sv
// Directed bench for slot_payout_scorer: hand-computed credit balances through wins,
// losses, aborts, saturation, reset mid-spin and credit exhaustion.
module tb_slot_payout_scorer;

    logic       clk = 1'b0;
    logic       reset;
    logic       stopInt;
    logic       allStopped;
    logic [3:0] randNum1, randNum2, randNum3, randNum4;
    logic [7:0] credits;
    logic [7:0] lastWin;
    logic [2:0] winClass;
    logic       resultValid;
    logic       busy;
    logic       noCredit;

    int vectors    = 0;
    int miscompares = 0;

    int scoreRv, holdRv, holdCredits, holdWin, holdClass, hold2Rv, hold2Busy, hold2Credits;

    slot_payout_scorer dut (
        .clk        (clk),
        .reset      (reset),
        .stopInt    (stopInt),
        .allStopped (allStopped),
        .randNum1   (randNum1),
        .randNum2   (randNum2),
        .randNum3   (randNum3),
        .randNum4   (randNum4),
        .credits    (credits),
        .lastWin    (lastWin),
        .winClass   (winClass),
        .resultValid(resultValid),
        .busy       (busy),
        .noCredit   (noCredit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One complete spin from IDLE back to IDLE, recording what was seen in SCORE and HOLD.
    task automatic applyStimulus(input logic [3:0] r1, input logic [3:0] r2,
                                 input logic [3:0] r3, input logic [3:0] r4);
        randNum1 = r1; randNum2 = r2; randNum3 = r3; randNum4 = r4;
        stopInt = 1'b1;
        tick();
        allStopped = 1'b1;
        tick();
        scoreRv = int'(resultValid);
        tick();
        holdRv      = int'(resultValid);
        holdCredits = int'(credits);
        holdWin     = int'(lastWin);
        holdClass   = int'(winClass);
        tick();
        hold2Rv      = int'(resultValid);
        hold2Busy    = int'(busy);
        hold2Credits = int'(credits);
        stopInt    = 1'b0;
        allStopped = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; stopInt = 1'b0; allStopped = 1'b0;
        randNum1 = 4'd0; randNum2 = 4'd0; randNum3 = 4'd0; randNum4 = 4'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("reset credits", int'(credits), 20);
        checkOutput("reset lastWin", int'(lastWin), 0);
        checkOutput("reset winClass", int'(winClass), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset noCredit", int'(noCredit), 0);

        // Jackpot, stepped manually to check the bet deduction and pulse timing.
        randNum1 = 4'd7; randNum2 = 4'd7; randNum3 = 4'd7; randNum4 = 4'd7;
        stopInt = 1'b1;
        tick();
        checkOutput("spin credits", int'(credits), 19);
        checkOutput("spin busy", int'(busy), 1);
        allStopped = 1'b1;
        tick();
        checkOutput("score rv", int'(resultValid), 0);
        tick();
        checkOutput("jackpot rv", int'(resultValid), 1);
        checkOutput("jackpot credits", int'(credits), 69);
        checkOutput("jackpot class", int'(winClass), 4);
        checkOutput("jackpot win", int'(lastWin), 50);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("hold rv", int'(resultValid), 0);
            checkOutput("hold busy", int'(busy), 1);
            checkOutput("hold no respin", int'(credits), 69);
        end
        stopInt = 1'b0; allStopped = 1'b0;
        tick();
        checkOutput("idle busy", int'(busy), 0);

        applyStimulus(4'd3, 4'd3, 4'd5, 4'd5);
        checkOutput("twopair score rv", scoreRv, 0);
        checkOutput("twopair rv", holdRv, 1);
        checkOutput("twopair credits", holdCredits, 73);
        checkOutput("twopair class", holdClass, 2);
        checkOutput("twopair win", holdWin, 5);
        checkOutput("twopair rv2", hold2Rv, 0);

        applyStimulus(4'd1, 4'd2, 4'd3, 4'd4);
        checkOutput("none credits", holdCredits, 72);
        checkOutput("none class", holdClass, 0);
        checkOutput("none win", holdWin, 0);

        applyStimulus(4'd2, 4'd2, 4'd6, 4'd9);
        checkOutput("pair credits", holdCredits, 73);
        checkOutput("pair class", holdClass, 1);
        checkOutput("pair win", holdWin, 2);

        applyStimulus(4'd8, 4'd8, 4'd8, 4'd1);
        checkOutput("three credits", holdCredits, 82);
        checkOutput("three class", holdClass, 3);
        checkOutput("three win", holdWin, 10);

        // Abort by dropping the request during SPIN.
        stopInt = 1'b1;
        tick();
        checkOutput("abort spin credits", int'(credits), 81);
        stopInt = 1'b0;
        tick();
        checkOutput("abort refund", int'(credits), 82);
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort rv", int'(resultValid), 0);
        checkOutput("abort keeps win", int'(lastWin), 10);
        checkOutput("abort keeps class", int'(winClass), 3);

        // Drop and allStopped in the same cycle: the abort wins.
        stopInt = 1'b1;
        tick();
        stopInt = 1'b0; allStopped = 1'b1;
        tick();
        allStopped = 1'b0;
        checkOutput("race refund", int'(credits), 82);
        checkOutput("race busy", int'(busy), 0);
        tick();
        checkOutput("race rv", int'(resultValid), 0);

        for (int i = 0; i < 3; i++) applyStimulus(4'd9, 4'd9, 4'd9, 4'd9);
        checkOutput("jackpots credits", holdCredits, 229);
        applyStimulus(4'd9, 4'd9, 4'd9, 4'd9);
        checkOutput("saturate 229", holdCredits, 255);
        for (int i = 0; i < 5; i++) applyStimulus(4'd0, 4'd1, 4'd2, 4'd3);
        checkOutput("down to 250", int'(credits), 250);
        applyStimulus(4'd15, 4'd15, 4'd15, 4'd15);
        checkOutput("saturate 250", holdCredits, 255);
        checkOutput("saturate win", holdWin, 50);

        // Reset in the middle of a spin.
        stopInt = 1'b1;
        tick();
        checkOutput("pre-reset busy", int'(busy), 1);
        checkOutput("pre-reset credits", int'(credits), 254);
        reset = 1'b1; stopInt = 1'b0;
        tick();
        reset = 1'b0;
        checkOutput("midspin reset credits", int'(credits), 20);
        checkOutput("midspin reset busy", int'(busy), 0);
        checkOutput("midspin reset win", int'(lastWin), 0);

        for (int i = 0; i < 20; i++) applyStimulus(4'd4, 4'd5, 4'd6, 4'd7);
        checkOutput("exhausted credits", int'(credits), 0);
        checkOutput("exhausted noCredit", int'(noCredit), 1);
        stopInt = 1'b1;
        tick();
        checkOutput("nocredit busy", int'(busy), 0);
        checkOutput("nocredit credits", int'(credits), 0);
        tick();
        checkOutput("nocredit still idle", int'(busy), 0);
        stopInt = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
